aes_ctr_stream_sequencer: RTL and testbench
===========================================

// Module: aes_ctr_stream_sequencer
// PURPOSE
//  Upstream controller for the single-block CTR engine; turns a block stream into per-block engine runs.
//  Holds the session key and the running counter, accepts 128-bit blocks on a valid/ready input,
//  pulses the engine once per block and returns its result on a valid/ready output.
//  Advances the counter per block and refuses traffic on counter wrap, preventing keystream reuse.
// PARAMETERS
//  CTR_WIDTH   32  low counter bits incremented per block (mod 2^CTR_WIDTH); upper 128-CTR_WIDTH bits fixed nonce
//  CNT_WIDTH   16  width of blocks_done counter (wraps silently)
// PORTS
//  clk             in   1    single clock, all logic on posedge
//  rst             in   1    synchronous, active-high reset
//  cfg_load        in   1    1-cycle pulse: latch cfg_key/cfg_iv, arm session
//  cfg_key         in   128  session key
//  cfg_iv          in   128  initial counter block
//  s_valid         in   1    input block valid
//  s_ready         out  1    sequencer accepts input block
//  s_data          in   128  plaintext/ciphertext block
//  s_last          in   1    final block of message
//  m_valid         out  1    output block valid
//  m_ready         in   1    downstream accepts output
//  m_data          out  128  processed block
//  m_last          out  1    copy of s_last for this block
//  eng_start       out  1    1-cycle start pulse to CTR engine
//  eng_key         out  128  key to engine (registered)
//  eng_iv_counter  out  128  current counter block to engine (registered)
//  eng_data_in     out  128  latched input block to engine (registered)
//  eng_data_out    in   128  engine result, valid when eng_done=1
//  eng_done        in   1    engine 1-cycle completion pulse
//  armed           out  1    session configured and usable
//  ctr_wrap        out  1    sticky: counter low field wrapped to 0
//  blocks_done     out  CNT_WIDTH  output handshakes since last cfg_load
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=S_IDLE; every output 0, incl. eng_* buses, m_data, armed, ctr_wrap, blocks_done.
//  FSM: S_IDLE -> S_ISSUE -> S_WAIT -> S_OUT -> S_IDLE.
//  s_ready = (state==S_IDLE) & armed & ~ctr_wrap; combinational from registers only.
//  S_IDLE: on s_valid&s_ready latch s_data->eng_data_in, s_last; eng_key/eng_iv_counter already hold session values; -> S_ISSUE.
//  S_ISSUE: eng_start=1 this cycle only; -> S_WAIT. eng_* buses stable from S_ISSUE until eng_done.
//  S_WAIT: on eng_done: m_data<=eng_data_out, m_last<=latched last, m_valid<=1; counter low field +1 mod 2^CTR_WIDTH;
//   if new low field==0 set ctr_wrap; -> S_OUT. Minimum latency: accept at T, eng_start T+1, m_valid cycle after eng_done.
//  S_OUT: m_valid held, m_data/m_last stable until m_valid&m_ready; on handshake m_valid<=0, blocks_done+1;
//   if m_last: armed<=0 (new cfg_load required per message); -> S_IDLE.
//  eng_done outside S_WAIT is ignored. No new input accepted while any block is outstanding (one block in flight).
//  cfg_load honoured only in S_IDLE: loads eng_key, eng_iv_counter; armed<=1; ctr_wrap<=0; blocks_done<=0.
//   cfg_load in any other state is ignored (no effect on any register).
//  cfg_load and s_valid in same S_IDLE cycle: cfg_load wins, block not accepted (s_ready evaluated from old armed).
//  Upper 128-CTR_WIDTH counter bits never change after cfg_load.
//  Reset mid-operation returns to S_IDLE with armed=0; engine is reset separately; stale eng_done after reset ignored.
// TESTING
//  NIST SP800-38A F.5.1: key 2b7e151628aed2a6abf7158809cf4f3c, iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, s_data 6bc1bee22e409f96e93d7e117393172a -> m_data 874d6191b620e3261bef6864990db6ce.
//  Second block ae2d8a571e03ac9c9eb76fac45af8e51 (s_last=1) -> eng_iv_counter ...fdff00, m_data 9806f66b7970fdff8617187bb9fffdff, m_last=1, blocks_done=2, armed=0.
//  Backpressure: m_ready=0 for 10 cycles -> m_valid=1, m_data stable, s_ready=0, no eng_start; release -> single handshake.
//  Wrap: CTR_WIDTH=32, iv low word ffffffff -> after block counter low=00000000, upper 96 bits unchanged, ctr_wrap=1, s_ready=0 until cfg_load.
//  cfg_load pulsed in S_WAIT -> eng_key/eng_iv_counter unchanged; spurious eng_done in S_IDLE -> no m_valid.
//  rst=1 in S_WAIT -> next cycle all outputs 0, state S_IDLE; later eng_done produces no m_valid.

Source files
------------

// File: rtl/aes_ctr_stream_sequencer.sv
// Upstream sequencer for a single-block CTR engine: one block in flight at a time.
// Holds the session key and running counter, pulses the engine per block and
// returns the engine result on a valid/ready output. The low counter field is
// incremented per block; on wrap the session refuses further traffic until reloaded.
module aes_ctr_stream_sequencer #(
  parameter int unsigned CTR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic [127:0]         cfg_key,
  input  logic [127:0]         cfg_iv,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [127:0]         s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [127:0]         m_data,
  output logic                 m_last,
  output logic                 eng_start,
  output logic [127:0]         eng_key,
  output logic [127:0]         eng_iv_counter,
  output logic [127:0]         eng_data_in,
  input  logic [127:0]         eng_data_out,
  input  logic                 eng_done,
  output logic                 armed,
  output logic                 ctr_wrap,
  output logic [CNT_WIDTH-1:0] blocks_done
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

  // Selects the incrementing low field; the remaining upper bits are the fixed nonce.
  localparam logic [127:0] CtrMask =
    (CTR_WIDTH >= 128) ? {128{1'b1}} : ((128'd1 << CTR_WIDTH) - 128'd1);

  state_e               state_q, state_d;
  logic [127:0]         key_q, key_d;
  logic [127:0]         ctr_q, ctr_d;
  logic [127:0]         din_q, din_d;
  logic                 last_q, last_d;
  logic [127:0]         mdata_q, mdata_d;
  logic                 mlast_q, mlast_d;
  logic                 mvalid_q, mvalid_d;
  logic                 armed_q, armed_d;
  logic                 wrap_q, wrap_d;
  logic [CNT_WIDTH-1:0] done_q, done_d;

  logic         accept;
  logic [127:0] ctr_inc;
  logic [127:0] ctr_next;

  // s_ready comes from registers only; a same-cycle cfg_load suppresses acceptance.
  assign accept   = s_valid & s_ready & ~cfg_load;
  assign ctr_inc  = ctr_q + 128'd1;
  assign ctr_next = (ctr_q & ~CtrMask) | (ctr_inc & CtrMask);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      key_q    <= '0;
      ctr_q    <= '0;
      din_q    <= '0;
      last_q   <= 1'b0;
      mdata_q  <= '0;
      mlast_q  <= 1'b0;
      mvalid_q <= 1'b0;
      armed_q  <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      ctr_q    <= ctr_d;
      din_q    <= din_d;
      last_q   <= last_d;
      mdata_q  <= mdata_d;
      mlast_q  <= mlast_d;
      mvalid_q <= mvalid_d;
      armed_q  <= armed_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (eng_done) state_d = StOut;
      StOut:   if (m_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values: config load, block capture, result capture, output handshake.
  always_comb begin
    key_d    = key_q;
    ctr_d    = ctr_q;
    din_d    = din_q;
    last_d   = last_q;
    mdata_d  = mdata_q;
    mlast_d  = mlast_q;
    mvalid_d = mvalid_q;
    armed_d  = armed_q;
    wrap_d   = wrap_q;
    done_d   = done_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_load) begin
          key_d   = cfg_key;
          ctr_d   = cfg_iv;
          armed_d = 1'b1;
          wrap_d  = 1'b0;
          done_d  = '0;
        end else if (accept) begin
          din_d  = s_data;
          last_d = s_last;
        end
      end
      StWait: begin
        if (eng_done) begin
          mdata_d  = eng_data_out;
          mlast_d  = last_q;
          mvalid_d = 1'b1;
          ctr_d    = ctr_next;
          if ((ctr_next & CtrMask) == 128'd0) wrap_d = 1'b1;
        end
      end
      StOut: begin
        if (m_ready) begin
          mvalid_d = 1'b0;
          done_d   = done_q + CNT_WIDTH'(1);
          // Each message needs a fresh session.
          if (mlast_q) armed_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state and registers.
  always_comb begin
    s_ready   = (state_q == StIdle) & armed_q & ~wrap_q;
    eng_start = (state_q == StIssue);
  end

  assign m_valid        = mvalid_q;
  assign m_data         = mdata_q;
  assign m_last         = mlast_q;
  assign eng_key        = key_q;
  assign eng_iv_counter = ctr_q;
  assign eng_data_in    = din_q;
  assign armed          = armed_q;
  assign ctr_wrap       = wrap_q;
  assign blocks_done    = done_q;

endmodule

// File: tb/tb_aes_ctr_stream_sequencer.sv
// Self-checking bench: the bench plays the CTR engine and keeps a scoreboard of
// expected output blocks plus a model of key, counter, armed, wrap and block count.
module tb_aes_ctr_stream_sequencer;
  localparam int unsigned CW = 32;
  localparam int unsigned NW = 16;
  localparam logic [127:0] MASK = (128'd1 << CW) - 128'd1;

  localparam logic [127:0] NK   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] NIV0 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] NIV1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] NP0  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] NC0  = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] NP1  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] NC1  = 128'h9806f66b7970fdff8617187bb9fffdff;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_load = 1'b0;
  logic [127:0]  cfg_key = '0;
  logic [127:0]  cfg_iv = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [127:0]  s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [127:0]  m_data;
  logic          m_last;
  logic          eng_start;
  logic [127:0]  eng_key;
  logic [127:0]  eng_iv_counter;
  logic [127:0]  eng_data_in;
  logic [127:0]  eng_data_out = '0;
  logic          eng_done = 1'b0;
  logic          armed;
  logic          ctr_wrap;
  logic [NW-1:0] blocks_done;

  int n_checks = 0;
  int n_fail = 0;

  logic [128:0] sb_q[$];
  logic [127:0] key_m = '0;
  logic [127:0] ctr_m = '0;
  logic         armed_m = 1'b0;
  logic         wrap_m = 1'b0;
  int           done_m = 0;

  aes_ctr_stream_sequencer #(.CTR_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .eng_start(eng_start), .eng_key(eng_key), .eng_iv_counter(eng_iv_counter),
    .eng_data_in(eng_data_in), .eng_data_out(eng_data_out), .eng_done(eng_done),
    .armed(armed), .ctr_wrap(ctr_wrap), .blocks_done(blocks_done)
  );

  always #5 clk = ~clk;

  // Engine stand-in: real AES results for the NIST vectors, a keyed mix otherwise.
  function automatic logic [127:0] eng_fn(input logic [127:0] k, input logic [127:0] c,
                                          input logic [127:0] d);
    if (k == NK && c == NIV0 && d == NP0) return NC0;
    if (k == NK && c == NIV1 && d == NP1) return NC1;
    return d ^ c ^ {k[63:0], k[127:64]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit all_zero();
    return (s_ready === 1'b0) && (m_valid === 1'b0) && (m_last === 1'b0) &&
           (eng_start === 1'b0) && (armed === 1'b0) && (ctr_wrap === 1'b0) &&
           (m_data === '0) && (eng_key === '0) && (eng_iv_counter === '0) &&
           (eng_data_in === '0) && (blocks_done === '0);
  endfunction

  task automatic do_cfg(input logic [127:0] k, input logic [127:0] iv);
    cfg_load = 1'b1; cfg_key = k; cfg_iv = iv;
    @(negedge clk);
    cfg_load = 1'b0;
    key_m = k; ctr_m = iv; armed_m = 1'b1; wrap_m = 1'b0; done_m = 0;
    n_checks++;
    if (armed !== 1'b1 || ctr_wrap !== 1'b0 || blocks_done !== '0 || eng_key !== k ||
        eng_iv_counter !== iv || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_load: armed=%b wrap=%b done=%0d key=%h ctr=%h rdy=%b want key=%h ctr=%h",
               armed, ctr_wrap, blocks_done, eng_key, eng_iv_counter, s_ready, k, iv);
    end
  endtask

  // One block through the sequencer; lat = extra engine cycles, bp = m_ready stall cycles,
  // glitch = pulse cfg_load while the engine is busy (needs lat >= 1).
  task automatic do_block(input logic [127:0] d, input bit last, input int lat, input int bp,
                          input bit glitch);
    logic [127:0] exp_ctr;
    logic [128:0] e;
    exp_ctr = ctr_m;
    sb_q.push_back({last, eng_fn(key_m, ctr_m, d)});
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++; $display("FAIL s_ready_idle: got %b want 1", s_ready);
    end
    s_valid = 1'b1; s_data = d; s_last = last;
    @(negedge clk);
    s_valid = 1'b0; s_data = rnd128(); s_last = 1'b0;
    n_checks++;
    if (eng_start !== 1'b1 || eng_data_in !== d || eng_iv_counter !== exp_ctr ||
        eng_key !== key_m || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL issue: start=%b din=%h ctr=%h key=%h rdy=%b want din=%h ctr=%h key=%h",
               eng_start, eng_data_in, eng_iv_counter, eng_key, s_ready, d, exp_ctr, key_m);
    end
    @(negedge clk);
    n_checks++;
    if (eng_start !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++; $display("FAIL start_pulse: start=%b rdy=%b want 0 0", eng_start, s_ready);
    end
    for (int i = 0; i < lat; i++) begin
      if (glitch && i == 0) begin
        cfg_load = 1'b1; cfg_key = ~key_m; cfg_iv = ~ctr_m;
      end
      @(negedge clk);
      cfg_load = 1'b0;
    end
    n_checks++;
    if (eng_key !== key_m || eng_iv_counter !== exp_ctr || eng_data_in !== d || m_valid !== 1'b0)
    begin
      n_fail++;
      $display("FAIL eng_stable: key=%h ctr=%h din=%h mv=%b want key=%h ctr=%h din=%h mv=0",
               eng_key, eng_iv_counter, eng_data_in, m_valid, key_m, exp_ctr, d);
    end
    eng_done = 1'b1; eng_data_out = eng_fn(eng_key, eng_iv_counter, eng_data_in);
    @(negedge clk);
    eng_done = 1'b0; eng_data_out = rnd128();
    ctr_m = (ctr_m & ~MASK) | ((ctr_m + 128'd1) & MASK);
    if ((ctr_m & MASK) == '0) wrap_m = 1'b1;
    for (int i = 0; i < bp; i++) begin
      n_checks++;
      if (m_valid !== 1'b1 || sb_q.size() == 0 || m_data !== sb_q[0][127:0] ||
          s_ready !== 1'b0 || eng_start !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure: mv=%b data=%h rdy=%b start=%b want mv=1 rdy=0 start=0",
                 m_valid, m_data, s_ready, eng_start);
      end
      @(negedge clk);
      eng_data_out = rnd128();
    end
    m_ready = 1'b1;
    n_checks++;
    if (m_valid !== 1'b1 || sb_q.size() == 0) begin
      n_fail++; $display("FAIL out_valid: mv=%b queued=%0d want mv=1", m_valid, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      n_checks++;
      if (m_data !== e[127:0] || m_last !== e[128]) begin
        n_fail++;
        $display("FAIL out_data: data=%h last=%b want data=%h last=%b",
                 m_data, m_last, e[127:0], e[128]);
      end
    end
    n_checks++;
    if (eng_iv_counter !== ctr_m || ctr_wrap !== wrap_m) begin
      n_fail++;
      $display("FAIL counter: ctr=%h wrap=%b want ctr=%h wrap=%b",
               eng_iv_counter, ctr_wrap, ctr_m, wrap_m);
    end
    @(negedge clk);
    m_ready = 1'b0;
    done_m++;
    if (last) armed_m = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || blocks_done !== NW'(done_m) || armed !== armed_m ||
        s_ready !== (armed_m & ~wrap_m)) begin
      n_fail++;
      $display("FAIL post_handshake: mv=%b done=%0d armed=%b rdy=%b want mv=0 done=%0d armed=%b rdy=%b",
               m_valid, blocks_done, armed, s_ready, done_m, armed_m, armed_m & ~wrap_m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!all_zero()) begin
      n_fail++; $display("FAIL reset_state: some output nonzero, armed=%b mv=%b", armed, m_valid);
    end
  endtask

  task automatic test_nist();
    do_cfg(NK, NIV0);
    do_block(NP0, 1'b0, 0, 0, 1'b0);
    do_block(NP1, 1'b1, 3, 0, 1'b0);
    n_checks++;
    if (blocks_done !== NW'(2) || armed !== 1'b0 || eng_iv_counter !== (NIV1 + 128'd1)) begin
      n_fail++;
      $display("FAIL nist_end: done=%0d armed=%b ctr=%h want done=2 armed=0",
               blocks_done, armed, eng_iv_counter);
    end
  endtask

  task automatic test_back_to_back();
    do_cfg(rnd128(), rnd128() & ~MASK);
    for (int i = 0; i < 4; i++) do_block(rnd128(), i == 3, i, i % 2, 1'b0);
  endtask

  task automatic test_backpressure();
    do_cfg(rnd128(), rnd128() & ~MASK);
    do_block(rnd128(), 1'b0, 1, 10, 1'b0);
  endtask

  task automatic test_cfg_in_wait();
    do_block(rnd128(), 1'b0, 2, 0, 1'b1);
  endtask

  task automatic test_spurious_done();
    eng_done = 1'b1; eng_data_out = rnd128();
    @(negedge clk);
    eng_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (m_valid !== 1'b0 || eng_start !== 1'b0 || s_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL spurious_done: mv=%b start=%b rdy=%b want 0 0 1", m_valid, eng_start, s_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cfg_vs_valid();
    logic [127:0] k;
    logic [127:0] iv;
    k = rnd128(); iv = rnd128() & ~MASK;
    cfg_load = 1'b1; cfg_key = k; cfg_iv = iv;
    s_valid = 1'b1; s_data = rnd128();
    @(negedge clk);
    cfg_load = 1'b0; s_valid = 1'b0;
    key_m = k; ctr_m = iv; armed_m = 1'b1; wrap_m = 1'b0; done_m = 0;
    n_checks++;
    if (eng_start !== 1'b0 || s_ready !== 1'b1 || eng_key !== k || eng_iv_counter !== iv ||
        blocks_done !== '0) begin
      n_fail++;
      $display("FAIL cfg_vs_valid: start=%b rdy=%b key=%h ctr=%h done=%0d want start=0 rdy=1",
               eng_start, s_ready, eng_key, eng_iv_counter, blocks_done);
    end
  endtask

  task automatic test_wrap();
    logic [127:0] iv;
    iv = (rnd128() & ~MASK) | MASK;
    do_cfg(rnd128(), iv);
    do_block(rnd128(), 1'b0, 1, 0, 1'b0);
    n_checks++;
    if (ctr_wrap !== 1'b1 || eng_iv_counter !== (iv & ~MASK) || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap: wrap=%b ctr=%h rdy=%b want wrap=1 ctr=%h rdy=0",
               ctr_wrap, eng_iv_counter, s_ready, iv & ~MASK);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (s_ready !== 1'b0) begin
      n_fail++; $display("FAIL wrap_hold: rdy=%b want 0", s_ready);
    end
    do_cfg(rnd128(), rnd128() & ~MASK);
  endtask

  task automatic test_reset_mid();
    s_valid = 1'b1; s_data = rnd128(); s_last = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    key_m = '0; ctr_m = '0; armed_m = 1'b0; wrap_m = 1'b0; done_m = 0;
    n_checks++;
    if (!all_zero()) begin
      n_fail++; $display("FAIL reset_mid: output nonzero, armed=%b start=%b", armed, eng_start);
    end
    eng_done = 1'b1; eng_data_out = rnd128();
    @(negedge clk);
    eng_done = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0 || armed !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_done: mv=%b armed=%b rdy=%b want 0 0 0", m_valid, armed, s_ready);
    end
    do_cfg(NK, NIV0);
    do_block(NP0, 1'b1, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_nist();
    test_back_to_back();
    test_backpressure();
    test_cfg_in_wait();
    test_spurious_done();
    test_cfg_vs_valid();
    test_wrap();
    test_reset_mid();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d left want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
